dco_tune_ctrl: RTL
==================

Name: dco_tune_ctrl

Overview:
- Consumer end of the frequency-loop correction interface: takes `freq_update` / `freq_incr_decr` strokes and turns them into DCO tuning codes.
- Drives the coarse (capacitor-bank) code by successive approximation, then tracks with a saturating fine code.
- Fine-code overflow re-centres the fine code and steps the coarse code.
- Enforces a settle time after every code change, and declares and withdraws DCO lock.
- Single clock domain (`ref_clk`); sits between the frequency loop and the DCO tuning inputs.

Parameters:
- CoarseBits, 6, coarse code width (≥2)
- FineBits, 8, fine code width (≥2)
- SettleCycles, 16, `ref_clk` cycles of settling after each code change (0 = none)
- LockCount, 4, consecutive direction reversals in FINE that declare lock
- UnlockCount, 8, consecutive same-direction steps in LOCKED that withdraw lock

Ports:
- ref_clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run tuning; low forces IDLE
- freq_update  input  1  one-cycle correction strobe
- freq_incr_decr  input  1  direction, sampled with `freq_update`: 1 = raise code, 0 = lower code
- coarse_code  output  CoarseBits  coarse tuning code (registered)
- fine_code  output  FineBits  fine tuning code (registered)
- code_change  output  1  one-cycle pulse in the cycle either code takes a new value
- settling  output  1  settle window active; strobes ignored
- dco_locked  output  1  lock flag
- tune_state  output  2  0 = IDLE, 1 = COARSE, 2 = FINE, 3 = LOCKED

Behaviour:
- One clock (`ref_clk`); reset is asynchronous and active-high (`reset`).
- Reset values:
  - coarse_code = 2^(CoarseBits-1)
  - fine_code = 2^(FineBits-1)
  - code_change = 0, settling = 0, dco_locked = 0
  - tune_state = IDLE; all counters 0
- enable = 0 (any state, including mid-settle):
  - next cycle tune_state = IDLE; codes hold.
  - settling = 0, dco_locked = 0.
  - enable has priority over a coincident strobe.
- IDLE → COARSE on enable = 1:
  - coarse_code and fine_code reload to mid-scale.
  - SAR bit index = CoarseBits-1.
  - code_change pulses even if the value is unchanged.
- Settle:
  - Every code_change loads the settle counter with SettleCycles.
  - settling = (counter ≠ 0), asserted in the same cycle as code_change; counter decrements each cycle.
- Strobe acceptance:
  - Accepted only when freq_update = 1, settling = 0, enable = 1 and state ≠ IDLE.
  - Otherwise dropped with no effect.
  - Accepted strobe → codes update on the next edge (latency 1).
- COARSE (SAR at bit i):
  - Direction 1 keeps bit i; 0 clears bit i.
  - If i > 0: set bit i-1 and i ← i-1.
  - If i = 0: go to FINE with fine_code unchanged (mid) and direction history cleared.
  - Every step produces code_change and settle, even if the value is unchanged.
- FINE / LOCKED step, direction 1:
  - fine < max: fine+1.
  - fine = max and coarse < max: coarse+1, fine = mid.
  - both at max: no change, no code_change, no settle.
- FINE / LOCKED step, direction 0: mirror image (fine-1; at fine = 0 with coarse > 0: coarse-1, fine = mid; both at 0: nothing).
- Direction tracking (FINE / LOCKED):
  - The first accepted strobe after entering FINE only records direction.
  - Later strobes: direction differs → reversal_cnt+1, same_cnt = 0; same direction → same_cnt+1, reversal_cnt = 0.
  - Saturated (no-change) strobes still count.
- FINE → LOCKED when reversal_cnt reaches LockCount; dco_locked = 1 in the same cycle tune_state = LOCKED.
- LOCKED → FINE when same_cnt reaches UnlockCount; dco_locked = 0 and counters clear.
- Counters are wide enough for their limits and saturate; no wrap.

Optional Feature:
- Macro: DCO_TUNE_DROP_CNT_EN.
- Defined:
  - Adds output `drop_cnt [7:0]`: counts freq_update strobes dropped while settling = 1 or state = IDLE.
  - Saturates at 255; cleared by reset or by the IDLE → COARSE transition.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset pulse mid-operation → asynchronous clear: coarse = 32, fine = 128, dco_locked = 0, settling = 0, tune_state = 0.
- enable = 1, then 6 settled strokes (1, 0, 1, 1, 0, 0) → coarse 32 → 48 → 40 → 44 → 46 → 45 → 44; tune_state = 2; each step shows code_change and then settling for 16 cycles.
- Strobe 5 cycles after code_change → dropped: no code change (`drop_cnt` = 1 with DCO_TUNE_DROP_CNT_EN).
- In FINE at fine = 128, settled strokes 1, 0, 1, 0, 1 → fine 129, 128, 129, 128, 129; dco_locked = 1 after the 5th; then 8 consecutive 1-strokes → dco_locked = 0 after the 8th, tune_state = 2.
- fine = 255, coarse = 44, stroke 1 → coarse = 45, fine = 128. At coarse = 63, fine = 255, stroke 1 → no code_change, settling stays 0.
- enable dropped mid-settle → next cycle tune_state = 0, settling = 0, codes held; re-enable → codes reload to 32 / 128 with code_change.

Source files
------------

// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl: turns frequency-loop correction strobes into DCO tuning codes.
// Coarse code is found by successive approximation, then a saturating fine code
// tracks. Fine overflow re-centres the fine code and steps the coarse code.
// A settle window follows every code change; lock is declared after repeated
// direction reversals and withdrawn after a long same-direction run.
// Optional feature macro: DCO_TUNE_DROP_CNT_EN adds the drop_cnt output.
//
// Strobe handshake: freq_update is a one-cycle strobe with freq_incr_decr valid
// alongside it; it is consumed only when enable=1, settling=0 and tune_state is
// not IDLE, otherwise it is dropped. settling acts as the inverse of ready.
module dco_tune_ctrl #(
    parameter int CoarseBits   = 6,
    parameter int FineBits     = 8,
    parameter int SettleCycles = 16,
    parameter int LockCount    = 4,
    parameter int UnlockCount  = 8
) (
    input  logic                  ref_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  freq_update,
    input  logic                  freq_incr_decr,
    output logic [CoarseBits-1:0] coarse_code,
    output logic [FineBits-1:0]   fine_code,
    output logic                  code_change,
    output logic                  settling,
    output logic                  dco_locked,
    output logic [1:0]            tune_state
`ifdef DCO_TUNE_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int SW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
    localparam int IW = (CoarseBits > 1) ? $clog2(CoarseBits) : 1;
    localparam int RW = (LockCount > 0) ? $clog2(LockCount + 1) : 1;
    localparam int UW = (UnlockCount > 0) ? $clog2(UnlockCount + 1) : 1;

    localparam logic [CoarseBits-1:0] COARSE_MID = {1'b1, {(CoarseBits-1){1'b0}}};
    localparam logic [CoarseBits-1:0] COARSE_MAX = '1;
    localparam logic [CoarseBits-1:0] COARSE_ONE = {{(CoarseBits-1){1'b0}}, 1'b1};
    localparam logic [FineBits-1:0]   FINE_MID   = {1'b1, {(FineBits-1){1'b0}}};
    localparam logic [FineBits-1:0]   FINE_MAX   = '1;
    localparam logic [FineBits-1:0]   FINE_ONE   = {{(FineBits-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]         IDX_TOP    = IW'(CoarseBits - 1);
    localparam logic [IW-1:0]         IDX_ONE    = IW'(1);
    localparam logic [SW-1:0]         SETTLE_LD  = SW'(SettleCycles);
    localparam logic [SW-1:0]         SETTLE_ONE = SW'(1);
    localparam logic [RW-1:0]         REV_LIM    = RW'(LockCount);
    localparam logic [RW-1:0]         REV_ONE    = RW'(1);
    localparam logic [UW-1:0]         SAME_LIM   = UW'(UnlockCount);
    localparam logic [UW-1:0]         SAME_ONE   = UW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   sar_idx;
    logic [SW-1:0]   settle_cnt;
    logic [RW-1:0]   rev_cnt;
    logic [UW-1:0]   same_cnt;
    logic            have_dir;
    logic            last_dir;

    logic                  accept;
    logic [CoarseBits-1:0] sar_coarse;
    logic [CoarseBits-1:0] step_coarse;
    logic [FineBits-1:0]   step_fine;
    logic                  step_moves;
    logic [RW-1:0]         nxt_rev;
    logic [UW-1:0]         nxt_same;

    assign tune_state = state;
    assign settling   = (settle_cnt != '0);
    assign accept     = freq_update && !settling && enable && (state != IDLE);

    // One SAR decision: keep or clear the bit under test, then trial-set the next lower bit.
    always_comb begin
        sar_coarse = coarse_code;
        if (!freq_incr_decr) sar_coarse[sar_idx] = 1'b0;
        if (sar_idx != '0) sar_coarse[sar_idx - IDX_ONE] = 1'b1;
    end

    // One tracking step: move the fine code, carrying into coarse at the rails, saturating at both ends.
    always_comb begin
        step_coarse = coarse_code;
        step_fine   = fine_code;
        step_moves  = 1'b0;
        if (freq_incr_decr) begin
            if (fine_code != FINE_MAX) begin
                step_fine  = fine_code + FINE_ONE;
                step_moves = 1'b1;
            end else if (coarse_code != COARSE_MAX) begin
                step_coarse = coarse_code + COARSE_ONE;
                step_fine   = FINE_MID;
                step_moves  = 1'b1;
            end
        end else begin
            if (fine_code != '0) begin
                step_fine  = fine_code - FINE_ONE;
                step_moves = 1'b1;
            end else if (coarse_code != '0) begin
                step_coarse = coarse_code - COARSE_ONE;
                step_fine   = FINE_MID;
                step_moves  = 1'b1;
            end
        end
    end

    // Direction history: reversal and same-direction run counters, saturating at their limits.
    always_comb begin
        nxt_rev  = rev_cnt;
        nxt_same = same_cnt;
        if (have_dir) begin
            if (freq_incr_decr != last_dir) begin
                nxt_rev  = (rev_cnt == REV_LIM) ? rev_cnt : rev_cnt + REV_ONE;
                nxt_same = '0;
            end else begin
                nxt_same = (same_cnt == SAME_LIM) ? same_cnt : same_cnt + SAME_ONE;
                nxt_rev  = '0;
            end
        end
    end

    // Tuning FSM with registered codes, change pulse, settle timer and lock flag.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            coarse_code <= COARSE_MID;
            fine_code   <= FINE_MID;
            code_change <= 1'b0;
            dco_locked  <= 1'b0;
            sar_idx     <= '0;
            settle_cnt  <= '0;
            rev_cnt     <= '0;
            same_cnt    <= '0;
            have_dir    <= 1'b0;
            last_dir    <= 1'b0;
        end else begin
            code_change <= 1'b0;
            if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_ONE;
            if (!enable) begin
                state      <= IDLE;
                settle_cnt <= '0;
                dco_locked <= 1'b0;
            end else if (state == IDLE) begin
                state       <= COARSE;
                coarse_code <= COARSE_MID;
                fine_code   <= FINE_MID;
                sar_idx     <= IDX_TOP;
                code_change <= 1'b1;
                settle_cnt  <= SETTLE_LD;
                rev_cnt     <= '0;
                same_cnt    <= '0;
                have_dir    <= 1'b0;
            end else if (accept) begin
                if (state == COARSE) begin
                    coarse_code <= sar_coarse;
                    code_change <= 1'b1;
                    settle_cnt  <= SETTLE_LD;
                    if (sar_idx == '0) begin
                        state    <= FINE;
                        have_dir <= 1'b0;
                        rev_cnt  <= '0;
                        same_cnt <= '0;
                    end else begin
                        sar_idx <= sar_idx - IDX_ONE;
                    end
                end else begin
                    if (step_moves) begin
                        coarse_code <= step_coarse;
                        fine_code   <= step_fine;
                        code_change <= 1'b1;
                        settle_cnt  <= SETTLE_LD;
                    end
                    have_dir <= 1'b1;
                    last_dir <= freq_incr_decr;
                    rev_cnt  <= nxt_rev;
                    same_cnt <= nxt_same;
                    if (state == FINE && nxt_rev == REV_LIM) begin
                        state      <= LOCKED;
                        dco_locked <= 1'b1;
                    end else if (state == LOCKED && nxt_same == SAME_LIM) begin
                        state      <= FINE;
                        dco_locked <= 1'b0;
                        rev_cnt    <= '0;
                        same_cnt   <= '0;
                        have_dir   <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef DCO_TUNE_DROP_CNT_EN
    // Saturating count of strobes lost to the settle window or to IDLE; restarts with each tuning run.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (enable && state == IDLE) begin
            drop_cnt <= '0;
        end else if (freq_update && (settling || state == IDLE) && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule
